// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_ctrl_pkg: FSM encoding, width defaults and shared ALU opcodes  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_ctrl_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int CODE_W_DEF = 3;

   localparam logic [CODE_W_DEF-1:0] ALU_ADD = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_ctrl_if: requester, ALU and response bundle              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface alu_share_ctrl_if #(
   parameter int WIDTH  = alu_ctrl_pkg::WIDTH_DEF,
   parameter int CODE_W = alu_ctrl_pkg::CODE_W_DEF
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*WIDTH-1:0]  req_a;
   logic [2*WIDTH-1:0]  req_b;
   logic [2*CODE_W-1:0] req_code;
   logic [WIDTH-1:0]    alu_a;
   logic [WIDTH-1:0]    alu_b;
   logic [CODE_W-1:0]   alu_code;
   logic [WIDTH-1:0]    alu_out;
   logic                alu_carry;
   logic                alu_zero;
   logic [1:0]          resp_valid;
   logic [1:0]          resp_ready;
   logic [WIDTH-1:0]    resp_data;
   logic                resp_carry;
   logic                resp_zero;
   logic                busy;

   // Controller side
   modport slave (
      input  req_valid, req_a, req_b, req_code, alu_out, alu_carry, alu_zero, resp_ready,
      output req_ready, alu_a, alu_b, alu_code, resp_valid, resp_data, resp_carry, resp_zero, busy
   );

   // Requesters plus ALU side
   modport master (
      output req_valid, req_a, req_b, req_code, alu_out, alu_carry, alu_zero, resp_ready,
      input  req_ready, alu_a, alu_b, alu_code, resp_valid, resp_data, resp_carry, resp_zero, busy
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2: two-way round-robin arbiter, one-hot grant                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arb2 (
   input  wire logic [1:0] req_i,
   input  wire logic       last_owner_i,
   input  wire logic       en_i,
   output logic [1:0]      grant_o
);

   // On a tie the requester that did not win last time goes first
   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_owner_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_ctrl: shares one ALU between two requesters              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CODE_W = CODE_W_DEF
) (
   input  wire logic        clk,
   input  wire logic        reset,
   alu_share_ctrl_if.slave  bus
);

   state_t            state_q, state_d;
   logic              owner_q;
   logic              last_owner_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [CODE_W-1:0] code_q;
   logic [WIDTH-1:0]  data_q;
   logic              carry_q, zero_q;
   logic [1:0]        grant;
   logic              g_idx;
   logic              arb_en;

   assign arb_en = (state_q == ST_IDLE) && !reset;
   assign g_idx  = grant[1];

   rr_arb2 u_arb (
      .req_i        (bus.req_valid),
      .last_owner_i (last_owner_q),
      .en_i         (arb_en),
      .grant_o      (grant)
   );

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = grant;
      bus.resp_valid = 2'b00;
      case (state_q)
         ST_IDLE: if (grant != 2'b00) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            bus.resp_valid = onehot2(owner_q);
            if (bus.resp_ready[owner_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         code_q       <= '0;
         data_q       <= '0;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && grant != 2'b00) begin
            a_q          <= g_idx ? bus.req_a[2*WIDTH-1:WIDTH]     : bus.req_a[WIDTH-1:0];
            b_q          <= g_idx ? bus.req_b[2*WIDTH-1:WIDTH]     : bus.req_b[WIDTH-1:0];
            code_q       <= g_idx ? bus.req_code[2*CODE_W-1:CODE_W] : bus.req_code[CODE_W-1:0];
            owner_q      <= g_idx;
            last_owner_q <= g_idx;
         end
         // The ALU result is only meaningful at the end of EXEC
         if (state_q == ST_EXEC) begin
            data_q  <= bus.alu_out;
            carry_q <= bus.alu_carry;
            zero_q  <= bus.alu_zero;
         end
      end
   end

   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_code   = code_q;
   assign bus.resp_data  = data_q;
   assign bus.resp_carry = carry_q;
   assign bus.resp_zero  = zero_q;
   assign bus.busy       = !reset && (state_q != ST_IDLE);

endmodule
`default_nettype wire
